// File: rtl/kernel_logic_pkg.sv
// Shared opCode field positions and the selected-digit record for kernel_logic.
package kernel_logic_pkg;

  localparam int OP_DIV_BIT    = 2;
  localparam int OP_SIGNED_BIT = 0;

  typedef struct packed {
    logic non0;
    logic sign_sel;
  } digit_t;

endpackage

// File: rtl/kernel_logic_qsel.sv
// SRT quotient-digit selection from the carry-save MSB estimate of the partial remainder.
module kernel_logic_qsel
  import kernel_logic_pkg::*;
#(
  parameter int csaBits = 4
) (
  input  logic signed [csaBits-1:0] sumMSBs,
  input  logic signed [csaBits-1:0] carryMSBs,
  input  logic                      ds,
  output digit_t                    digit
);

  // Estimate wraps modulo 2^csaBits, so the most negative code lands in the y<=-2 band.
  logic signed [csaBits-1:0] y;
  assign y = sumMSBs + carryMSBs;

  always_comb begin
    digit = '0;
    if (!y[csaBits-1]) begin
      digit.non0     = 1'b1;
      digit.sign_sel = ~ds;
    end else if (&y) begin
      digit.non0     = 1'b0;
      digit.sign_sel = 1'b0;
    end else begin
      digit.non0     = 1'b1;
      digit.sign_sel = ds;
    end
  end

endmodule

// File: rtl/kernel_logic.sv
// Divider/multiplier addend selector; KERNEL_LOGIC_OUT_REG_EN registers the outputs,
// otherwise the block is purely combinational and clk/rst_n are unused.
module kernel_logic
  import kernel_logic_pkg::*;
#(
  parameter int parallelism = 32,
  parameter int csaBits     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [parallelism:0]      data,
  input  logic [parallelism:0]      notData,
  input  logic                      saveReminder,
  input  logic [2:0]                opCode,
  input  logic signed [csaBits-1:0] sumMSBs,
  input  logic signed [csaBits-1:0] carryMSBs,
  input  logic                      z_MSB,
  input  logic                      d_MSB,
  output logic                      SignSel,
  output logic                      Non0,
  output logic [parallelism:0]      outData
);

  logic              ds;
  digit_t            qsel_digit;
  digit_t            digit_d;
  logic [parallelism:0] out_d;

  // Unsigned operations never see the divisor sign.
  assign ds = d_MSB & opCode[OP_SIGNED_BIT];

  kernel_logic_qsel #(.csaBits(csaBits)) u_qsel (
    .sumMSBs  (sumMSBs),
    .carryMSBs(carryMSBs),
    .ds       (ds),
    .digit    (qsel_digit)
  );

  always_comb begin
    digit_d = '0;
    if (opCode[OP_DIV_BIT] && !saveReminder) begin
      digit_d = qsel_digit;
    end else begin
      digit_d.non0     = z_MSB;
      digit_d.sign_sel = z_MSB & ds;
    end
    if (!digit_d.non0) digit_d.sign_sel = 1'b0;
  end

  always_comb begin
    out_d = '0;
    if (digit_d.non0) out_d = digit_d.sign_sel ? notData : data;
  end

  logic unused_op;
  assign unused_op = opCode[1];

`ifdef KERNEL_LOGIC_OUT_REG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SignSel <= 1'b0;
      Non0    <= 1'b0;
      outData <= '0;
    end else begin
      SignSel <= digit_d.sign_sel;
      Non0    <= digit_d.non0;
      outData <= out_d;
    end
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  assign SignSel = digit_d.sign_sel;
  assign Non0    = digit_d.non0;
  assign outData = out_d;
`endif

endmodule

// File: tb/tb_kernel_logic.sv
// Directed-vector bench for kernel_logic; adapts latency/reset checks to KERNEL_LOGIC_OUT_REG_EN.
module tb_kernel_logic;

  localparam int PAR = 32;
  localparam int CSA = 4;
  localparam logic [PAR:0] D = 33'h1_FFFF_FFFE;
  localparam logic [PAR:0] N = 33'h0_0000_0002;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [PAR:0]      data, notData;
  logic              saveReminder;
  logic [2:0]        opCode;
  logic [CSA-1:0]    sumMSBs, carryMSBs;
  logic              z_MSB, d_MSB;
  logic              SignSel, Non0;
  logic [PAR:0]      outData;

  int checks = 0;
  int errors = 0;

  kernel_logic #(.parallelism(PAR), .csaBits(CSA)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data        (data),
    .notData     (notData),
    .saveReminder(saveReminder),
    .opCode      (opCode),
    .sumMSBs     (sumMSBs),
    .carryMSBs   (carryMSBs),
    .z_MSB       (z_MSB),
    .d_MSB       (d_MSB),
    .SignSel     (SignSel),
    .Non0        (Non0),
    .outData     (outData)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string          name;
    logic [2:0]     op;
    logic           save;
    logic [CSA-1:0] sum;
    logic [CSA-1:0] carry;
    logic           z;
    logic           d;
    logic           e_non0;
    logic           e_sign;
    logic [1:0]     e_sel;   // 0 zero, 1 data, 2 notData
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [PAR:0] act, input logic [PAR:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    opCode = v.op; saveReminder = v.save; sumMSBs = v.sum; carryMSBs = v.carry;
    z_MSB = v.z; d_MSB = v.d;
  endtask

  function automatic logic [PAR:0] exp_out(input logic [1:0] sel, input logic [PAR:0] dd,
                                           input logic [PAR:0] nd);
    case (sel)
      2'd1:    return dd;
      2'd2:    return nd;
      default: return '0;
    endcase
  endfunction

  task automatic check_vec(input vec_t v, input string tag, input logic [PAR:0] dd,
                           input logic [PAR:0] nd);
    check({tag, " ", v.name, " Non0"},    {32'b0, Non0},    {32'b0, v.e_non0});
    check({tag, " ", v.name, " SignSel"}, {32'b0, SignSel}, {32'b0, v.e_sign});
    check({tag, " ", v.name, " outData"}, outData, exp_out(v.e_sel, dd, nd));
  endtask

  initial begin
    //         name         op      sv   sum     carry   z  d  n0 ss sel
    vecs[0]  = '{"div_y0",      3'b100, 0, 4'b0000, 4'b0000, 0, 0, 1, 1, 2};
    vecs[1]  = '{"div_ym1",     3'b100, 0, 4'b0000, 4'b1111, 0, 0, 0, 0, 0};
    vecs[2]  = '{"div_ym4",     3'b100, 0, 4'b0000, 4'b1100, 0, 0, 1, 0, 1};
    vecs[3]  = '{"sdiv_y0_d1",  3'b101, 0, 4'b0000, 4'b0000, 0, 1, 1, 0, 1};
    vecs[4]  = '{"udiv_y0_d1",  3'b100, 0, 4'b0000, 4'b0000, 0, 1, 1, 1, 2};
    vecs[5]  = '{"corr_z1",     3'b101, 1, 4'b1111, 4'b0000, 1, 1, 1, 1, 2};
    vecs[6]  = '{"corr_z0",     3'b101, 1, 4'b1111, 4'b0000, 0, 1, 0, 0, 0};
    vecs[7]  = '{"umul_z1",     3'b000, 0, 4'b0111, 4'b0000, 1, 1, 1, 0, 1};
    vecs[8]  = '{"umul_z0",     3'b000, 0, 4'b0111, 4'b0000, 0, 1, 0, 0, 0};
    vecs[9]  = '{"smul_z1",     3'b001, 0, 4'b0000, 4'b0000, 1, 1, 1, 1, 2};
    vecs[10] = '{"sdiv_ym8",    3'b101, 0, 4'b1000, 4'b0000, 0, 1, 1, 1, 2};
    vecs[11] = '{"sdiv_yp7",    3'b101, 0, 4'b0111, 4'b0000, 0, 1, 1, 0, 1};
    vecs[12] = '{"sdiv_wrap",   3'b101, 0, 4'b0111, 4'b0001, 0, 1, 1, 1, 2};
    vecs[13] = '{"sdiv_ym1",    3'b101, 0, 4'b0111, 4'b1000, 1, 1, 0, 0, 0};
    vecs[14] = '{"op110_y0",    3'b110, 0, 4'b0000, 4'b0000, 0, 1, 1, 1, 2};
    vecs[15] = '{"ucorr_z1",    3'b100, 1, 4'b0000, 4'b0000, 1, 1, 1, 0, 1};
    vecs[16] = '{"smul_save_z0",3'b001, 1, 4'b0000, 4'b0000, 0, 1, 0, 0, 0};
    vecs[17] = '{"sdiv_ym2_d0", 3'b101, 0, 4'b1110, 4'b0000, 1, 0, 1, 0, 1};

    data = D; notData = N;
    rst_n = 1'b1;
    drive(vecs[0]);
    #1 rst_n = 1'b0;
    #2;
`ifdef KERNEL_LOGIC_OUT_REG_EN
    check("reset_noclk Non0",    {32'b0, Non0},    33'd0);
    check("reset_noclk SignSel", {32'b0, SignSel}, 33'd0);
    check("reset_noclk outData", outData,          33'd0);
    @(posedge clk); #1;
    check("reset_clk outData", outData, 33'd0);
`else
    check_vec(vecs[0], "comb_in_reset", D, N);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_vec(vecs[0], "first_edge", D, N);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk); #1;
      check_vec(vecs[i], "vec", D, N);
    end

    // Second operand pattern to exercise every outData bit of the mux.
    @(negedge clk);
    data = 33'h0_A5A5_5A5A; notData = ~33'h0_A5A5_5A5A;
    drive(vecs[3]);
    @(posedge clk); #1;
    check_vec(vecs[3], "alt_data", 33'h0_A5A5_5A5A, ~33'h0_A5A5_5A5A);
    @(negedge clk);
    drive(vecs[4]);
    @(posedge clk); #1;
    check_vec(vecs[4], "alt_notdata", 33'h0_A5A5_5A5A, ~33'h0_A5A5_5A5A);
    data = D; notData = N;

    // Latency: new inputs after an edge must not show before the next edge.
    @(negedge clk);
    drive(vecs[0]);
    @(posedge clk); #1;
    drive(vecs[1]);
    #2;
`ifdef KERNEL_LOGIC_OUT_REG_EN
    check_vec(vecs[0], "hold_until_edge", D, N);
    @(posedge clk); #1;
    check_vec(vecs[1], "after_edge", D, N);
`else
    check_vec(vecs[1], "zero_latency", D, N);
`endif

    // Reset asserted mid-operation.
    @(negedge clk);
    drive(vecs[2]);
    @(posedge clk); #1;
    check_vec(vecs[2], "pre_reset", D, N);
    #2 rst_n = 1'b0;
    #1;
`ifdef KERNEL_LOGIC_OUT_REG_EN
    check("midreset Non0",    {32'b0, Non0}, 33'd0);
    check("midreset outData", outData,       33'd0);
    @(posedge clk); #1;
    check("midreset_edge outData", outData, 33'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("released_before_edge outData", outData, 33'd0);
    @(posedge clk); #1;
    check_vec(vecs[2], "post_reset", D, N);
`else
    check_vec(vecs[2], "comb_midreset", D, N);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kernel_logic.md
KERNEL_LOGIC -- requirements
Module: kernel_logic

Interface
REQ-001 Parameter parallelism, default 32: operand width; datapaths are parallelism+1 bits.
REQ-002 Parameter csaBits, default 4: width of the carry-save MSB estimate fields.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 rst_n  input  1: reset, asynchronous, active-low.
REQ-005 data  input  parallelism+1: divisor/multiplicand, true form.
REQ-006 notData  input  parallelism+1: bitwise complement of data, supplied externally.
REQ-007 saveReminder  input  1: remainder-correction step.
REQ-008 opCode  input  3: bit2=1 divide family, bit2=0 multiply; bit0=1 signed operands; bit1 is ignored here.
REQ-009 sumMSBs  input  csaBits, signed: top bits of the partial-remainder sum word.
REQ-010 carryMSBs  input  csaBits, signed: top bits of the partial-remainder carry word.
REQ-011 z_MSB  input  1: remainder sign (divide, correction) or current multiplier bit (multiply).
REQ-012 d_MSB  input  1: divisor sign (divide) or final-step flag (multiply).
REQ-013 SignSel  output  1: 1 = outData is notData; also the adder carry-in.
REQ-014 Non0  output  1: 1 = nonzero digit selected.
REQ-015 outData  output  parallelism+1: selected addend: data, notData or zero.

Function
REQ-016 Estimate y = sumMSBs + carryMSBs, csaBits-bit signed, wraps modulo 2^csaBits.
REQ-017 Effective sign ds = d_MSB AND opCode[0]; with opCode[0]=0, d_MSB is ignored in all modes.
REQ-018 Divide, saveReminder=0: y>=0 -> Non0=1, SignSel=NOT ds; y=-1 -> Non0=0, SignSel=0; y<=-2 -> Non0=1, SignSel=ds.
REQ-019 Divide, saveReminder=1: Non0=z_MSB; SignSel=z_MSB AND ds; sumMSBs/carryMSBs are ignored.
REQ-020 Multiply (opCode[2]=0): Non0=z_MSB; SignSel=z_MSB AND ds; saveReminder, sumMSBs and carryMSBs are ignored.
REQ-021 outData = notData when Non0=1 and SignSel=1; data when Non0=1 and SignSel=0; all zeros when Non0=0.
REQ-022 SignSel is forced to 0 whenever Non0=0.
REQ-023 Outputs are registered: the value for the inputs sampled at rising edge n appears after that edge and holds until edge n+1. Latency is one cycle, with no handshake.
REQ-024 Boundary: y=-2^(csaBits-1) (most negative) is classified as y<=-2; y=2^(csaBits-1)-1 is classified as y>=0.

Reset
REQ-025 While rst_n=0, SignSel=0, Non0=0 and outData=0 immediately, independent of clk.
REQ-026 The first registered update occurs at the first rising clk edge after rst_n deasserts.
REQ-027 Reset asserted mid-operation discards the pending selection with no residual state.

Configuration
REQ-028 Macro KERNEL_LOGIC_OUT_REG_EN: when defined, REQ-023 applies (registered outputs).
REQ-029 When KERNEL_LOGIC_OUT_REG_EN is undefined, outputs are purely combinational from the inputs, zero latency, and clk and rst_n are unused (ports retained).

Structure
REQ-030 Package kernel_logic_pkg holds the opCode field constants (OP_DIV_BIT=2, OP_SIGNED_BIT=0) and the digit typedef {Non0, SignSel}.
REQ-031 Sub-module kernel_logic_qsel performs estimate addition and SRT digit classification (REQ-016..018, REQ-024); the top level handles muxing and registers.

Verification (parallelism=32, csaBits=4, macro defined; D=0x1_FFFF_FFFE, N=0x0_0000_0002)
REQ-032 rst_n=0 with arbitrary inputs -> SignSel=0, Non0=0 and outData=0 without any clock edge.
REQ-033 opCode=100, saveReminder=0, sum=0000, carry=0000, data=D, notData=N -> next cycle Non0=1, SignSel=1, outData=N.
REQ-034 opCode=100, saveReminder=0, sum=0000, carry=1111 (y=-1) -> Non0=0, SignSel=0, outData=0; carry=1100 (y=-4) -> Non0=1, SignSel=0, outData=D.
REQ-035 opCode=101, saveReminder=0, y=0, d_MSB=1 -> Non0=1, SignSel=0, outData=D; same inputs with opCode=100 -> SignSel=1, outData=N.
REQ-036 opCode=101, saveReminder=1, z_MSB=1, d_MSB=1 -> Non0=1, SignSel=1, outData=N; z_MSB=0 -> outData=0.
REQ-037 opCode=000, z_MSB=1, d_MSB=1, sum=0111 -> Non0=1, SignSel=0, outData=D; z_MSB=0 -> outData=0.
